wbuf_drain: RTL and testbench
=============================

# wbuf_drain

Drain engine for the cache write buffer: pops {strobe, data, address} entries from the compare-FIFO and issues them as single-beat writes on the memory-side valid/ready port. Holds the entry in flight in an output register and reports address hazards against it, because the FIFO's compare covers only queued entries. Optionally retries on write errors. Sits between the write-buffer FIFO read port and the memory arbiter.

## Interface
- W_ADDR, 32, address width; entry bits [W_ADDR-1:0].
- W_DATA, 32, data width; entry bits [W_ADDR+W_DATA-1:W_ADDR]; must be a multiple of 8.
- W_ENTRY, W_ADDR+W_DATA+W_DATA/8, FIFO entry width; strobes in the top W_DATA/8 bits.
- C_MAX_RETRY, 3, retries per entry (retry build only), 1..15.
- C_BACKOFF, 4, idle cycles before a retry, 1..255.
- sClk_i  in  1  clock, rising edge.
- snRst_i  in  1  asynchronous active-low reset.
- FifoEmpty_i  in  1  FIFO empty.
- FifoData_i  in  W_ENTRY  FIFO head, valid combinationally while FifoEmpty_i=0.
- FifoRead_o  out  1  pop strobe, combinational.
- MemValid_o  out  1  write request valid.
- MemAddr_o / MemWData_o / MemWStrb_o  out  W_ADDR / W_DATA / W_DATA/8  request payload, registered.
- MemReady_i  in  1  request accepted/completed this cycle.
- MemErr_i  in  1  error response, qualified by MemValid_o & MemReady_i.
- ChkAddr_i  in  W_ADDR  read-miss address to check.
- Hazard_o  out  1  MemValid_o & (MemAddr_o == ChkAddr_i), combinational.
- Idle_o  out  1  FifoEmpty_i & state IDLE, combinational.
- ErrSticky_o  out  1  an entry was dropped after error.
- ErrAddr_o  out  W_ADDR  address of the first dropped entry.
- ErrClr_i  in  1  clears ErrSticky_o and ErrAddr_o.

## Operation
- States: IDLE, ISSUE, BACKOFF (BACKOFF exists only in the retry build).
- FifoRead_o = ~FifoEmpty_i & (IDLE | (ISSUE & MemReady_i & ~Retry_w)); Retry_w is high when MemErr_i and the entry is retried.
- On FifoRead_o the payload registers load FifoData_i; the state goes to/stays in ISSUE; the retry counter clears.
- ISSUE: MemValid_o=1. Payload is held stable until MemReady_i.
- On MemReady_i with no pop, the state goes to IDLE and MemValid_o falls.
- MemReady_i & MemErr_i, retry build: if RetryCnt < C_MAX_RETRY, the state goes to BACKOFF with MemValid_o=0, the payload is kept, and RetryCnt is incremented. Otherwise the entry is dropped.
- Drop action: if ErrSticky_o=0, set ErrSticky_o=1 and capture ErrAddr_o = MemAddr_o. Then continue as for a normal completion.
- BACKOFF: a down-counter is loaded with C_BACKOFF and counts to 0, then the state goes to ISSUE. No pop occurs in BACKOFF.
- Hazard_o is 0 in BACKOFF. The miss path stalls on Hazard_o or the FIFO compare result; in BACKOFF the entry is protected only by an external retry lockout.
- ErrClr_i has priority over a new error in the same cycle; the error is lost.

## Timing
- Reset values:
  - state IDLE; MemValid_o=0.
  - payload, ErrAddr_o, and counters 0; ErrSticky_o=0.
  - FifoRead_o = ~FifoEmpty_i, but it has no effect during reset.
- Latency: FIFO non-empty in cycle N gives a pop in N and MemValid_o in N+1.
- Throughput: one entry per cycle with MemReady_i held high.
- Empty at completion: IDLE for at least one cycle.
- Reset mid-transfer: the in-flight entry is lost, and MemValid_o drops asynchronously.
- Retry: a retried write reappears C_BACKOFF+1 cycles after the error response.

## Configuration
- WBUF_DRAIN_RETRY_EN defined: BACKOFF state, retry and backoff counters, and behaviour as above.
- WBUF_DRAIN_RETRY_EN undefined: every error drops the entry immediately. C_MAX_RETRY and C_BACKOFF are ignored, and no BACKOFF logic is generated.

## Structure
- Shared cache package:
  - entry field offsets and widths (address LSB=0, matching the FIFO compare position);
  - the state encoding localparam (IDLE=0, ISSUE=1, BACKOFF=2).
- Sub-module: wbuf_drain_backoff, a loadable down-counter with a done flag, instantiated only under WBUF_DRAIN_RETRY_EN.

## Test plan
- Three entries preloaded and MemReady_i=1:
  - pops occur in cycles 0, 1, 2;
  - MemValid_o is high in cycles 1–3 with addresses 0x100, 0x104, 0x108;
  - Idle_o returns to 1 in cycle 4.
- MemReady_i held low for 5 cycles: the payload is stable, FifoRead_o=0, and Hazard_o=1 for ChkAddr_i=0x100 and 0 for 0x104.
- Single error, retry build, C_BACKOFF=4:
  - MemValid_o is low for 4 cycles, then the same address and data are reissued;
  - ErrSticky_o stays 0.
- Error on every attempt with C_MAX_RETRY=3: after 4 attempts the entry is dropped, ErrSticky_o=1 and ErrAddr_o=0x200, and the next entry then issues.
- Non-retry build, error on 0x300 then on 0x304: ErrAddr_o holds 0x300; ErrClr_i clears ErrSticky_o and ErrAddr_o to 0.
- snRst_i asserted mid-ISSUE: MemValid_o=0 immediately; after release, the state is IDLE and a queued entry pops one cycle later.

Source files
------------

// File: rtl/wbuf_drain_pkg.sv
// wbuf_drain shared package: FIFO entry layout and drain FSM encoding.
// Entry layout is {strobe, data, address}, address at bit 0.
package wbuf_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BACKOFF = 2'd2
  } state_e;

  localparam int ADDR_LSB = 0;
  localparam int W_BKO    = 8;
  localparam int W_RTY    = 4;

  function automatic int data_lsb(input int w_addr);
    return ADDR_LSB + w_addr;
  endfunction

  function automatic int strb_lsb(input int w_addr, input int w_data);
    return ADDR_LSB + w_addr + w_data;
  endfunction

endpackage

// File: rtl/wbuf_drain_backoff.sv
// wbuf_drain_backoff: loadable down-counter gating the retry backoff.
// done_o flags the cycle in which the count reaches zero.
module wbuf_drain_backoff
  import wbuf_drain_pkg::*;
#(
  parameter int W = W_BKO
) (
  input  logic         sClk_i,
  input  logic         snRst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // load on retry, otherwise count down while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // counter register
  always_ff @(posedge sClk_i or negedge snRst_i) begin
    if (!snRst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i & (cnt_q <= W'(1));

endmodule

// File: rtl/wbuf_drain.sv
// wbuf_drain: pops write-buffer entries and issues single-beat writes.
// WBUF_DRAIN_RETRY_EN enables retry with backoff on write errors.
module wbuf_drain
  import wbuf_drain_pkg::*;
#(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int W_ENTRY     = W_ADDR + W_DATA + W_DATA / 8,
  parameter int C_MAX_RETRY = 3,
  parameter int C_BACKOFF   = 4
) (
  input  logic                sClk_i,
  input  logic                snRst_i,
  input  logic                FifoEmpty_i,
  input  logic [W_ENTRY-1:0]  FifoData_i,
  output logic                FifoRead_o,
  output logic                MemValid_o,
  output logic [W_ADDR-1:0]   MemAddr_o,
  output logic [W_DATA-1:0]   MemWData_o,
  output logic [W_DATA/8-1:0] MemWStrb_o,
  input  logic                MemReady_i,
  input  logic                MemErr_i,
  input  logic [W_ADDR-1:0]   ChkAddr_i,
  output logic                Hazard_o,
  output logic                Idle_o,
  output logic                ErrSticky_o,
  output logic [W_ADDR-1:0]   ErrAddr_o,
  input  logic                ErrClr_i
);

  localparam int W_STRB = W_DATA / 8;
  localparam int D_LSB  = data_lsb(W_ADDR);
  localparam int S_LSB  = strb_lsb(W_ADDR, W_DATA);

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [W_ADDR-1:0]   addr_q, addr_d;
  logic [W_DATA-1:0]   data_q, data_d;
  logic [W_STRB-1:0]   strb_q, strb_d;
  logic                err_sticky_q, err_sticky_d;
  logic [W_ADDR-1:0]   err_addr_q, err_addr_d;

  logic hs_w;
  logic err_w;
  logic retry_w;
  logic drop_w;
  logic pop_w;
  logic done_w;

  assign hs_w  = valid_q & MemReady_i;
  assign err_w = hs_w & MemErr_i;

`ifdef WBUF_DRAIN_RETRY_EN
  logic [W_RTY-1:0] rty_q, rty_d;
  logic             bko_done_w;
  logic             resume_w;

  assign retry_w  = err_w & (rty_q < W_RTY'(C_MAX_RETRY));
  assign resume_w = (state_q == ST_BACKOFF) & bko_done_w;

  wbuf_drain_backoff #(
    .W (W_BKO)
  ) u_backoff (
    .sClk_i     (sClk_i),
    .snRst_i    (snRst_i),
    .load_i     (retry_w),
    .load_val_i (W_BKO'(C_BACKOFF)),
    .en_i       (state_q == ST_BACKOFF),
    .done_o     (bko_done_w)
  );
`else
  assign retry_w = 1'b0;
`endif

  assign drop_w = err_w & ~retry_w;
  assign pop_w  = ~FifoEmpty_i
                & ((state_q == ST_IDLE)
                 | ((state_q == ST_ISSUE) & MemReady_i & ~retry_w));
  assign done_w = hs_w & ~retry_w & ~pop_w;

  // drain FSM: pop/issue, retry into backoff, or fall back to idle
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
`ifdef WBUF_DRAIN_RETRY_EN
    rty_d   = rty_q;
`endif
    unique case (1'b1)
      pop_w: begin
        state_d = ST_ISSUE;
        valid_d = 1'b1;
        addr_d  = FifoData_i[ADDR_LSB +: W_ADDR];
        data_d  = FifoData_i[D_LSB +: W_DATA];
        strb_d  = FifoData_i[S_LSB +: W_STRB];
`ifdef WBUF_DRAIN_RETRY_EN
        rty_d   = '0;
`endif
      end
`ifdef WBUF_DRAIN_RETRY_EN
      retry_w: begin
        state_d = ST_BACKOFF;
        valid_d = 1'b0;
        rty_d   = rty_q + W_RTY'(1);
      end
      resume_w: begin
        state_d = ST_ISSUE;
        valid_d = 1'b1;
      end
`endif
      done_w: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // first dropped entry latches; clear wins over a new drop
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    if (ErrClr_i) begin
      err_sticky_d = 1'b0;
      err_addr_d   = '0;
    end else if (drop_w && !err_sticky_q) begin
      err_sticky_d = 1'b1;
      err_addr_d   = addr_q;
    end
  end

  // state, payload and error registers
  always_ff @(posedge sClk_i or negedge snRst_i) begin
    if (!snRst_i) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
`ifdef WBUF_DRAIN_RETRY_EN
      rty_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
`ifdef WBUF_DRAIN_RETRY_EN
      rty_q        <= rty_d;
`endif
    end
  end

  assign FifoRead_o  = pop_w;
  assign MemValid_o  = valid_q;
  assign MemAddr_o   = addr_q;
  assign MemWData_o  = data_q;
  assign MemWStrb_o  = strb_q;
  assign Hazard_o    = valid_q & (addr_q == ChkAddr_i);
  assign Idle_o      = FifoEmpty_i & (state_q == ST_IDLE);
  assign ErrSticky_o = err_sticky_q;
  assign ErrAddr_o   = err_addr_q;

endmodule

// File: tb/tb_wbuf_drain.sv
// tb_wbuf_drain: directed and randomized checks of the write-buffer drain.
// Retry scenarios are exercised when WBUF_DRAIN_RETRY_EN is defined.
module tb_wbuf_drain;

  localparam int W_ADDR  = 32;
  localparam int W_DATA  = 32;
  localparam int W_ENTRY = W_ADDR + W_DATA + W_DATA / 8;
  localparam int MAXR    = 3;
  localparam int BKO     = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               FifoEmpty_i;
  logic [W_ENTRY-1:0] FifoData_i;
  logic               FifoRead_o;
  logic               MemValid_o;
  logic [31:0]        MemAddr_o;
  logic [31:0]        MemWData_o;
  logic [3:0]         MemWStrb_o;
  logic               MemReady_i = 1'b0;
  logic               MemErr_i = 1'b0;
  logic [31:0]        ChkAddr_i = '0;
  logic               Hazard_o;
  logic               Idle_o;
  logic               ErrSticky_o;
  logic [31:0]        ErrAddr_o;
  logic               ErrClr_i = 1'b0;

  logic [W_ENTRY-1:0] fq[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wbuf_drain #(
    .W_ADDR      (W_ADDR),
    .W_DATA      (W_DATA),
    .W_ENTRY     (W_ENTRY),
    .C_MAX_RETRY (MAXR),
    .C_BACKOFF   (BKO)
  ) dut (
    .sClk_i      (clk),
    .snRst_i     (rst_n),
    .FifoEmpty_i (FifoEmpty_i),
    .FifoData_i  (FifoData_i),
    .FifoRead_o  (FifoRead_o),
    .MemValid_o  (MemValid_o),
    .MemAddr_o   (MemAddr_o),
    .MemWData_o  (MemWData_o),
    .MemWStrb_o  (MemWStrb_o),
    .MemReady_i  (MemReady_i),
    .MemErr_i    (MemErr_i),
    .ChkAddr_i   (ChkAddr_i),
    .Hazard_o    (Hazard_o),
    .Idle_o      (Idle_o),
    .ErrSticky_o (ErrSticky_o),
    .ErrAddr_o   (ErrAddr_o),
    .ErrClr_i    (ErrClr_i)
  );

  task automatic refresh();
    FifoEmpty_i = (fq.size() == 0);
    FifoData_i  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    fq.push_back({s, d, a});
    refresh();
  endtask

  // one clock: pops the tb FIFO if the DUT strobed read out of reset
  task automatic step();
    logic pop;
    #1;
    pop = FifoRead_o & ~FifoEmpty_i & rst_n;
    @(posedge clk);
    #1;
    if (pop) void'(fq.pop_front());
    refresh();
    @(negedge clk);
  endtask

  task automatic clear_err();
    ErrClr_i = 1'b1;
    step();
    ErrClr_i = 1'b0;
  endtask

  task automatic test_reset();
    refresh();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b want 0", MemValid_o);
    end
    n_cmp++;
    if ({MemAddr_o, MemWData_o, MemWStrb_o} !== '0) begin
      n_err++; $display("FAIL rst_payload: got %h/%h want 0", MemAddr_o, MemWData_o);
    end
    n_cmp++;
    if ({ErrSticky_o, ErrAddr_o} !== '0) begin
      n_err++; $display("FAIL rst_err: got %b/%h want 0", ErrSticky_o, ErrAddr_o);
    end
    push(32'h80, 32'hAAAA_5555, 4'hF);
    #1;
    n_cmp++;
    if (FifoRead_o !== 1'b1) begin
      n_err++; $display("FAIL rst_read: got %b want 1", FifoRead_o);
    end
    step();
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b0 || fq.size() != 1) begin
      n_err++; $display("FAIL rst_noeffect: got %b want 0", MemValid_o);
    end
    rst_n = 1'b1;
    MemReady_i = 1'b1;
    repeat (3) step();
    #1;
    n_cmp++;
    if (Idle_o !== 1'b1) begin
      n_err++; $display("FAIL rst_drain_idle: got %b want 1", Idle_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] d[3];
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      push(32'h100 + 32'(4 * i), d[i], 4'(i + 1));
    end
    MemReady_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (FifoRead_o !== (c < 3)) begin
        n_err++; $display("FAIL stream_pop c%0d: got %b want %b", c, FifoRead_o, c < 3);
      end
      n_cmp++;
      if (MemValid_o !== (c >= 1 && c <= 3)) begin
        n_err++; $display("FAIL stream_valid c%0d: got %b", c, MemValid_o);
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (MemAddr_o !== 32'h100 + 32'(4 * (c - 1)) || MemWData_o !== d[c-1]) begin
          n_err++; $display("FAIL stream_addr c%0d: got %h/%h want %h/%h", c, MemAddr_o,
            MemWData_o, 32'h100 + 32'(4 * (c - 1)), d[c-1]);
        end
      end
      n_cmp++;
      if (Idle_o !== (c == 4)) begin
        n_err++; $display("FAIL stream_idle c%0d: got %b want %b", c, Idle_o, c == 4);
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] da;
    da = $urandom;
    push(32'h100, da, 4'hF);
    push(32'h104, ~da, 4'h3);
    MemReady_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      ChkAddr_i = 32'h100;
      #1;
      n_cmp++;
      if (MemValid_o !== 1'b1 || MemAddr_o !== 32'h100 || MemWData_o !== da) begin
        n_err++; $display("FAIL stall_hold c%0d: got %b %h %h want 1 100 %h", c, MemValid_o,
          MemAddr_o, MemWData_o, da);
      end
      n_cmp++;
      if (FifoRead_o !== 1'b0) begin
        n_err++; $display("FAIL stall_read c%0d: got %b want 0", c, FifoRead_o);
      end
      n_cmp++;
      if (Hazard_o !== 1'b1) begin
        n_err++; $display("FAIL stall_haz_hit c%0d: got %b want 1", c, Hazard_o);
      end
      ChkAddr_i = 32'h104;
      #1;
      n_cmp++;
      if (Hazard_o !== 1'b0) begin
        n_err++; $display("FAIL stall_haz_miss c%0d: got %b want 0", c, Hazard_o);
      end
      step();
    end
    MemReady_i = 1'b1;
    step();
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b1 || MemAddr_o !== 32'h104 || MemWData_o !== ~da) begin
      n_err++; $display("FAIL stall_next: got %b %h want 1 104", MemValid_o, MemAddr_o);
    end
    repeat (2) step();
  endtask

`ifndef WBUF_DRAIN_RETRY_EN
  task automatic test_drop();
    clear_err();
    push(32'h300, 32'h1, 4'hF);
    push(32'h304, 32'h2, 4'hF);
    MemReady_i = 1'b1;
    MemErr_i = 1'b1;
    repeat (4) step();
    MemErr_i = 1'b0;
    #1;
    n_cmp++;
    if (ErrSticky_o !== 1'b1 || ErrAddr_o !== 32'h300) begin
      n_err++; $display("FAIL drop_first: got %b %h want 1 300", ErrSticky_o, ErrAddr_o);
    end
    clear_err();
    #1;
    n_cmp++;
    if (ErrSticky_o !== 1'b0 || ErrAddr_o !== 32'h0) begin
      n_err++; $display("FAIL drop_clr: got %b %h want 0 0", ErrSticky_o, ErrAddr_o);
    end
    push(32'h308, 32'h3, 4'hF);
    step();
    MemErr_i = 1'b1;
    ErrClr_i = 1'b1;
    step();
    MemErr_i = 1'b0;
    ErrClr_i = 1'b0;
    #1;
    n_cmp++;
    if (ErrSticky_o !== 1'b0 || ErrAddr_o !== 32'h0) begin
      n_err++; $display("FAIL drop_clr_prio: got %b %h want 0 0", ErrSticky_o, ErrAddr_o);
    end
    step();
  endtask
`else
  task automatic test_retry();
    logic [31:0] d;
    clear_err();
    d = $urandom;
    push(32'h180, d, 4'h5);
    MemReady_i = 1'b1;
    step();
    MemErr_i = 1'b1;
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b1) begin
      n_err++; $display("FAIL retry_first: got %b want 1", MemValid_o);
    end
    step();
    MemErr_i = 1'b0;
    for (int c = 0; c < BKO; c++) begin
      #1;
      n_cmp++;
      if (MemValid_o !== 1'b0) begin
        n_err++; $display("FAIL retry_gap c%0d: got %b want 0", c, MemValid_o);
      end
      step();
    end
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b1 || MemAddr_o !== 32'h180 || MemWData_o !== d) begin
      n_err++; $display("FAIL retry_reissue: got %b %h %h want 1 180 %h", MemValid_o,
        MemAddr_o, MemWData_o, d);
    end
    step();
    #1;
    n_cmp++;
    if (ErrSticky_o !== 1'b0) begin
      n_err++; $display("FAIL retry_sticky: got %b want 0", ErrSticky_o);
    end
  endtask

  task automatic test_retry_drop();
    int att = 0;
    bit seen = 0;
    clear_err();
    push(32'h200, 32'h11, 4'hF);
    push(32'h204, 32'h22, 4'hF);
    MemReady_i = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      #1;
      if (MemValid_o && MemAddr_o == 32'h204) begin
        seen = 1;
        MemErr_i = 1'b0;
      end else begin
        MemErr_i = 1'b1;
        if (MemValid_o && MemAddr_o == 32'h200) att++;
      end
      step();
    end
    MemErr_i = 1'b0;
    n_cmp++;
    if (!seen || att != MAXR + 1) begin
      n_err++; $display("FAIL retry_attempts: got %0d seen %0d want %0d", att, seen, MAXR + 1);
    end
    #1;
    n_cmp++;
    if (ErrSticky_o !== 1'b1 || ErrAddr_o !== 32'h200) begin
      n_err++; $display("FAIL retry_drop: got %b %h want 1 200", ErrSticky_o, ErrAddr_o);
    end
    step();
  endtask
`endif

  task automatic test_random();
    logic [W_ENTRY-1:0] exp_q[$];
    logic [W_ENTRY-1:0] head;
    logic m_sticky;
    logic [31:0] m_addr;
    logic hs, err, drop, pop, clr;
    int att = 0;
    bit done = 0;
    clear_err();
    m_sticky = 1'b0;
    m_addr = '0;
    for (int c = 0; c < 700 && !done; c++) begin
      if (c < 400) begin
        if ($urandom_range(0, 2) == 0 && fq.size() < 6)
          push(32'h1000 + 32'($urandom_range(0, 63) << 2), $urandom,
               4'($urandom_range(1, 15)));
        MemReady_i = ($urandom_range(0, 2) != 0);
        MemErr_i = ($urandom_range(0, 4) == 0);
        ErrClr_i = ($urandom_range(0, 22) == 0);
      end else begin
        MemReady_i = 1'b1;
        MemErr_i = 1'b0;
        ErrClr_i = 1'b0;
      end
      #1;
      if (c >= 400 && fq.size() == 0 && exp_q.size() == 0 && Idle_o) begin
        done = 1;
      end else begin
        drop = 1'b0;
        hs = MemValid_o & MemReady_i;
        err = hs & MemErr_i;
        clr = ErrClr_i;
        if (MemValid_o) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL rnd_spurious: got valid %h want none", MemAddr_o);
          end else if ({MemWStrb_o, MemWData_o, MemAddr_o} !== exp_q[0]) begin
            n_err++; $display("FAIL rnd_payload: got %h want %h",
              {MemWStrb_o, MemWData_o, MemAddr_o}, exp_q[0]);
          end
        end
        if (hs && exp_q.size() != 0) begin
`ifdef WBUF_DRAIN_RETRY_EN
          if (err && att < MAXR) begin
            att++;
          end else begin
            drop = err;
            m_addr = drop && !m_sticky && !clr ? exp_q[0][31:0] : m_addr;
            void'(exp_q.pop_front());
            att = 0;
          end
`else
          drop = err;
          m_addr = drop && !m_sticky && !clr ? exp_q[0][31:0] : m_addr;
          void'(exp_q.pop_front());
`endif
        end
        pop = FifoRead_o & ~FifoEmpty_i;
        head = FifoData_i;
        step();
        if (pop) exp_q.push_back(head);
        if (clr) begin
          m_sticky = 1'b0;
          m_addr = '0;
        end else if (drop) begin
          m_sticky = 1'b1;
        end
        #1;
        n_cmp++;
        if (ErrSticky_o !== m_sticky || ErrAddr_o !== m_addr) begin
          n_err++; $display("FAIL rnd_err c%0d: got %b %h want %b %h", c, ErrSticky_o,
            ErrAddr_o, m_sticky, m_addr);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL rnd_drain: got busy want idle");
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    push(32'h400, 32'h44, 4'hF);
    MemReady_i = 1'b0;
    step();
    push(32'h404, 32'h55, 4'hF);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got %b want 0", MemValid_o);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b0 || FifoRead_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_idle: got %b %b want 0 1", MemValid_o, FifoRead_o);
    end
    step();
    #1;
    n_cmp++;
    if (MemValid_o !== 1'b1 || MemAddr_o !== 32'h404) begin
      n_err++; $display("FAIL rstmid_next: got %b %h want 1 404", MemValid_o, MemAddr_o);
    end
    MemReady_i = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
`ifndef WBUF_DRAIN_RETRY_EN
    test_drop();
`else
    test_retry();
    test_retry_drop();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
